// File: rtl/dcache_pkg.sv
// Shared definitions for the MEM-stage data cache: RV32I access-size encodings,
// refill FSM states, address-field width helpers and store lane formatting.
package dcache_pkg;

    localparam int NUM_LINES_DFLT  = 64;
    localparam int LINE_WORDS_DFLT = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2
    } dcache_state_t;

    function automatic int offset_w(int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int index_w(int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(int num_lines, int line_words);
        return 32 - offset_w(line_words) - index_w(num_lines);
    endfunction

    localparam int OFFSET_W = offset_w(LINE_WORDS_DFLT);
    localparam int INDEX_W  = index_w(NUM_LINES_DFLT);
    localparam int TAG_W    = tag_w(NUM_LINES_DFLT, LINE_WORDS_DFLT);

    // Misaligned halves/words are aligned down by ignoring the low lane bits.
    function automatic logic [3:0] store_be(logic [2:0] f3, logic [1:0] lane);
        case (f3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return 4'b0011 << {lane[1], 1'b0};
            F3_W:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(logic [2:0] f3, logic [31:0] data);
        case (f3)
            F3_B:    return {4{data[7:0]}};
            F3_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache: combinational read,
// synchronous byte-enabled data write, and tag/valid update with valid cleared on rst.
module dcache_array import dcache_pkg::*; #(
    parameter int NUM_LINES  = NUM_LINES_DFLT,
    parameter int LINE_WORDS = LINE_WORDS_DFLT,
    localparam int IW = index_w(NUM_LINES),
    localparam int WW = $clog2(LINE_WORDS),
    localparam int TW = tag_w(NUM_LINES, LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_index,
    input  logic [WW-1:0] rd_word,
    output logic [TW-1:0] rd_tag,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    input  logic          data_we,
    input  logic [IW-1:0] wr_index,
    input  logic [WW-1:0] wr_word,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic          meta_we,
    input  logic [IW-1:0] meta_index,
    input  logic [TW-1:0] meta_tag,
    input  logic          meta_valid
);

    logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];
    logic [TW-1:0]        tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    assign rd_data  = data_mem[rd_index][rd_word];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];

    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_mem[meta_index] <= meta_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (meta_we) begin
            valid[meta_index] <= meta_valid;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage with a blocking, direct-mapped, write-through, no-write-allocate
// data cache and word-serial refill. Define DCACHE_STATS_EN to add hit/miss/store counters.
module memory_stage import dcache_pkg::*; #(
    parameter int NUM_LINES  = NUM_LINES_DFLT,
    parameter int LINE_WORDS = LINE_WORDS_DFLT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   aluResultM,
    input  logic [31:0]   writeDataM,
    input  logic          memReadM,
    input  logic          memWriteM,
    input  logic [2:0]    funct3M,
    output logic [31:0]   readDataM,
    output logic          stallM,
    output logic          memReqValid,
    input  logic          memReqReady,
    output logic          memReqWrite,
    output logic [31:0]   memReqAddr,
    output logic [31:0]   memReqWdata,
    output logic [3:0]    memReqBe,
    input  logic          memRespValid,
    input  logic [31:0]   memRespData,
`ifdef DCACHE_STATS_EN
    output logic [31:0]   loadHitCnt,
    output logic [31:0]   loadMissCnt,
    output logic [31:0]   storeCnt,
`endif
    output dcache_state_t dbg_state
);

    localparam int OW = offset_w(LINE_WORDS);
    localparam int IW = index_w(NUM_LINES);
    localparam int WW = $clog2(LINE_WORDS);
    localparam int TW = tag_w(NUM_LINES, LINE_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

    dcache_state_t state;
    logic [WW-1:0] cnt;
    logic [31-OW:0] refill_line;

    logic [IW-1:0] acc_index;
    logic [WW-1:0] acc_word;
    logic [TW-1:0] acc_tag;
    logic [TW-1:0] rd_tag;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          hit, is_load, is_store;
    logic          miss_start, store_fire, fill_fire, fill_last;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign acc_index = aluResultM[OW+IW-1:OW];
    assign acc_word  = aluResultM[OW-1:2];
    assign acc_tag   = aluResultM[31:OW+IW];
    assign hit       = rd_valid && (rd_tag == acc_tag);

    // A store wins when both strobes are set; the pair is illegal upstream.
    assign is_store   = memWriteM;
    assign is_load    = memReadM && !memWriteM;
    assign miss_start = (state == IDLE) && is_load && !hit;
    assign store_fire = (state == IDLE) && is_store && memReqReady;
    assign fill_fire  = (state == REFILL_WAIT) && memRespValid;
    assign fill_last  = fill_fire && (cnt == LAST_WORD);
    assign st_be      = store_be(funct3M, aluResultM[1:0]);
    assign st_wdata   = store_lanes(funct3M, writeDataM);
    assign dbg_state  = state;

    // The line is invalidated on miss entry and revalidated only after its last word lands.
    dcache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (acc_index),
        .rd_word    (acc_word),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .data_we    (!rst && (fill_fire || (store_fire && hit))),
        .wr_index   (fill_fire ? refill_line[IW-1:0] : acc_index),
        .wr_word    (fill_fire ? cnt : acc_word),
        .wr_be      (fill_fire ? 4'hF : st_be),
        .wr_data    (fill_fire ? memRespData : st_wdata),
        .meta_we    (!rst && (miss_start || fill_last)),
        .meta_index (fill_last ? refill_line[IW-1:0] : acc_index),
        .meta_tag   (refill_line[31-OW:IW]),
        .meta_valid (fill_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            refill_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        state       <= REFILL_REQ;
                        cnt         <= '0;
                        refill_line <= aluResultM[31:OW];
                    end
                end
                REFILL_REQ: begin
                    if (memReqReady) state <= REFILL_WAIT;
                end
                REFILL_WAIT: begin
                    if (memRespValid) begin
                        if (cnt == LAST_WORD) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= REFILL_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // memReq handshake: a transfer happens on a cycle with memReqValid && memReqReady;
    // while memReqValid is high and memReqReady low, every memReq field holds its value.
    always_comb begin
        memReqValid = 1'b0;
        memReqWrite = 1'b0;
        memReqAddr  = '0;
        memReqWdata = '0;
        memReqBe    = 4'h0;
        stallM      = 1'b0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    memReqValid = 1'b1;
                    memReqWrite = 1'b1;
                    memReqAddr  = {aluResultM[31:2], 2'b00};
                    memReqWdata = st_wdata;
                    memReqBe    = st_be;
                    stallM      = !memReqReady;
                end else if (is_load && !hit) begin
                    stallM = 1'b1;
                end
            end
            REFILL_REQ: begin
                memReqValid = 1'b1;
                memReqBe    = 4'hF;
                memReqAddr  = {refill_line, cnt, 2'b00};
                stallM      = 1'b1;
            end
            REFILL_WAIT: stallM = 1'b1;
            default: stallM = 1'b0;
        endcase
    end

    always_comb begin
        case (aluResultM[1:0])
            2'd0:    ld_byte = rd_data[7:0];
            2'd1:    ld_byte = rd_data[15:8];
            2'd2:    ld_byte = rd_data[23:16];
            default: ld_byte = rd_data[31:24];
        endcase
        ld_half   = aluResultM[1] ? rd_data[31:16] : rd_data[15:0];
        readDataM = '0;
        if ((state == IDLE) && is_load && hit) begin
            case (funct3M)
                F3_B:    readDataM = {{24{ld_byte[7]}}, ld_byte};
                F3_H:    readDataM = {{16{ld_half[15]}}, ld_half};
                F3_W:    readDataM = rd_data;
                F3_BU:   readDataM = {24'b0, ld_byte};
                F3_HU:   readDataM = {16'b0, ld_half};
                default: readDataM = '0;
            endcase
        end
    end

    a_no_load_store_overlap: assert property (@(posedge clk) disable iff (rst) !(memReadM && memWriteM));

`ifdef DCACHE_STATS_EN
    // The load that retires right after its refill was already counted as a miss.
    logic just_filled;

    always_ff @(posedge clk) begin
        if (rst) begin
            just_filled <= 1'b0;
            loadHitCnt  <= '0;
            loadMissCnt <= '0;
            storeCnt    <= '0;
        end else begin
            just_filled <= fill_last;
            if ((state == IDLE) && is_load && hit && !just_filled && (loadHitCnt != '1))
                loadHitCnt <= loadHitCnt + 1'b1;
            if (miss_start && (loadMissCnt != '1))
                loadMissCnt <= loadMissCnt + 1'b1;
            if (store_fire && (storeCnt != '1))
                storeCnt <= storeCnt + 1'b1;
        end
    end
`endif

endmodule
